// File: rtl/processor_control_pkg.sv
// Shared A8Q2 definitions: state encodings, opcode/funct constants and small helpers.
package processor_control_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_RF     = 3'd3,
    ST_EX     = 3'd4,
    ST_WB     = 3'd5,
    ST_OUTPUT = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Register whose value the register file presents during OUTPUT.
  localparam logic [4:0] OUTPUT_REG = 5'd4;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/processor_control_alu.sv
// Combinational 8-bit execute unit; flags any opcode/funct it cannot execute.
module alu8
  import processor_control_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm8,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [7:0] y,
  output logic       invalid
);

  always_comb begin
    y       = 8'd0;
    invalid = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  y = a + b;
        FN_SUB:  y = a - b;
        FN_AND:  y = a & b;
        FN_OR:   y = a | b;
        FN_SLT:  y = {7'd0, ($signed(a) < $signed(b))};
        default: invalid = 1'b1;
      endcase
    end else if (opcode == OP_ADDIU) begin
      y = a + imm8;
    end else begin
      invalid = 1'b1;
    end
  end

endmodule

// File: rtl/processor_control.sv
// A8Q2 multi-cycle sequencer: fetch/decode/execute and register-file handshake.
//
// state  | meaning
// IDLE   | waiting for start after reset
// FETCH  | latch instr into IR, clear invalid flag
// DECODE | fields stable; halt goes to OUTPUT, else flag invalid
// RF     | register file samples rs/rt
// EX     | result <= alu(rsv, rtv, IR)
// WB     | register file writes rd; advance pc
// OUTPUT | register file presents r4 and raises done
// HALT   | capture r4 once on rf_done; start restarts from pc 0
module processor_control
  import processor_control_pkg::*;
#(
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  output logic [PC_W-1:0] instr_addr,
  input  logic [31:0]     instr,
  output logic [2:0]      state,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      rd,
  output logic [7:0]      result,
  output logic            instruction_invalid,
  input  logic [7:0]      rsv,
  input  logic [7:0]      rtv,
  input  logic            rf_done,
  output logic            busy,
  output logic            halted,
  output logic [7:0]      out_value,
  output logic [7:0]      invalid_count
);

  localparam logic [PC_W-1:0] PC_LAST = '1;

  state_t          st;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic            captured;
  logic [7:0]      alu_y;
  logic            alu_inv;
  logic            unused_ir_bits;

  alu8 u_alu (
    .a       (rsv),
    .b       (rtv),
    .imm8    (ir[7:0]),
    .opcode  (ir[31:26]),
    .funct   (ir[5:0]),
    .y       (alu_y),
    .invalid (alu_inv)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st                  <= ST_IDLE;
      pc                  <= '0;
      ir                  <= '0;
      result              <= '0;
      instruction_invalid <= 1'b0;
      out_value           <= '0;
      invalid_count       <= '0;
      captured            <= 1'b0;
    end else begin
      case (st)
        ST_IDLE: begin
          if (start) begin
            pc            <= '0;
            invalid_count <= '0;
            st            <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          ir                  <= instr;
          instruction_invalid <= 1'b0;
          st                  <= ST_DECODE;
        end
        ST_DECODE: begin
          if (ir[31:26] == OP_HALT) begin
            st <= ST_OUTPUT;
          end else begin
            instruction_invalid <= alu_inv;
            st                  <= ST_RF;
          end
        end
        ST_RF: st <= ST_EX;
        ST_EX: begin
          result <= alu_y;
          st     <= ST_WB;
        end
        ST_WB: begin
          if (instruction_invalid) invalid_count <= sat_inc8(invalid_count);
          // Last address ends the run instead of wrapping back to 0.
          if (pc == PC_LAST) begin
            st <= ST_OUTPUT;
          end else begin
            pc <= pc + 1'b1;
            st <= ST_FETCH;
          end
        end
        ST_OUTPUT: begin
          captured <= 1'b0;
          st       <= ST_HALT;
        end
        ST_HALT: begin
          if (start) begin
            pc            <= '0;
            invalid_count <= '0;
            st            <= ST_FETCH;
          end else if (rf_done && !captured) begin
            out_value <= rsv;
            captured  <= 1'b1;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign instr_addr     = pc;
  assign state          = st;
  assign rs             = ir[25:21];
  assign rt             = ir[20:16];
  assign rd             = (ir[31:26] == OP_ADDIU) ? ir[20:16] : ir[15:11];
  assign busy           = (st != ST_IDLE) && (st != ST_HALT);
  assign halted         = (st == ST_HALT);
  assign unused_ir_bits = ^ir[10:8];

endmodule

// File: doc/processor_control.md
Name: processor_control

Overview:
- Multi-cycle sequencer and 8-bit execute unit for the A8Q2 processor. It is the initiator on the register-file interface.
- Fetches 32-bit instructions from an external combinational instruction ROM and decodes them.
- Drives state/rs/rt/rd/result/instruction_invalid to register_file and consumes rsv/rtv/done.
- Computes ALU results and, on halt, collects the final value of r4 through the register file's OUTPUT handshake.

Parameters:
- PC_W, 5, instruction address width. The program holds at most 2^PC_W instructions.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  level; sampled in IDLE or HALT; starts a run from pc=0.
- instr_addr  output  PC_W  ROM address; equals pc.
- instr  input  32  ROM data, combinational from instr_addr.
- state  output  3  current FSM state; encoding from the shared header.
- rs  output  5  instr[25:21] of the latched instruction register (IR).
- rt  output  5  IR[20:16].
- rd  output  5  write destination: IR[15:11] for R-type, IR[20:16] for addiu.
- result  output  8  registered ALU result.
- instruction_invalid  output  1  current instruction is undecodable; register file suppresses its write.
- rsv  input  8  register file read data A; also carries r4 in OUTPUT.
- rtv  input  8  register file read data B.
- rf_done  input  1  register file done flag.
- busy  output  1  high in every state except IDLE and HALT.
- halted  output  1  high in HALT.
- out_value  output  8  r4 value captured at end of run.
- invalid_count  output  8  saturating count of invalid instructions in the current run.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, pc=0, IR=0, result=0, instruction_invalid=0, out_value=0, invalid_count=0.
  - rs, rt, rd read 0. busy=0, halted=0.
  - Reset mid-run abandons the instruction; an in-flight WB write does not happen because state leaves WB.
- States (3-bit): IDLE=0, FETCH=1, DECODE=2, RF=3, EX=4, WB=5, OUTPUT=6, HALT=7.
- Transitions:
  - IDLE: start=1 -> FETCH with pc=0 and invalid_count=0; otherwise stay.
  - FETCH: IR<=instr -> DECODE.
  - DECODE: field outputs are stable this cycle.
    - If opcode=6'h3F (halt) -> OUTPUT.
    - Otherwise set instruction_invalid per the decode below -> RF.
  - RF: register_file latches rsv/rtv at this edge. They are valid no later than the next edge, within a 2-unit propagation delay -> EX.
  - EX: result<=alu(rsv,rtv,IR) -> WB.
  - WB: outputs held stable; register file writes at this edge.
    - pc<=pc+1. If instruction_invalid, invalid_count increments, saturating at 255.
    - If pc == 2^PC_W-1 -> OUTPUT; no wrap, an implicit halt. Otherwise -> FETCH.
  - OUTPUT: one cycle; register file drives rsv=r4 and sets done -> HALT.
  - HALT: on the first cycle with rf_done=1, out_value<=rsv, captured once per run. start=1 -> FETCH with pc=0 and invalid_count=0. A start arriving before the capture also restarts the run.
- Decode:
  - opcode 0, funct:
    - 6'h20 add: rs+rt mod 256.
    - 6'h22 sub: rs-rt mod 256.
    - 6'h24 and.
    - 6'h25 or.
    - 6'h2A slt: signed 8-bit compare, result 1 or 0.
  - opcode 6'h09 addiu: rsv + IR[7:0] mod 256; destination rt.
  - Any other opcode or funct: instruction_invalid=1 and result=0. The FSM still traverses RF, EX and WB.
- Register-file rules: rd=0 writes are suppressed by the register file; the controller drives rd unchanged. instruction_invalid is cleared in FETCH.
- Ownership: rsv, rtv and rf_done are never assumed valid outside EX (rsv, rtv) and HALT (rsv, rf_done).
- start is ignored while busy.

Decomposition:
- Shared header A8Q2_state_defs.h: all eight STATE_* encodings; opcode/funct constants (OP_RTYPE, OP_ADDIU, OP_HALT, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT); OUTPUT_REG=4.
- One combinational sub-module, alu8 (inputs a, b, imm8, op select; output 8-bit result plus invalid flag). The FSM, PC, IR and counters stay in processor_control.

Test Plan:
- ROM {addiu r1,r0,5; addiu r2,r0,3; add r4,r1,r2; halt}, start pulse:
  - state sequence 1,2,3,4,5 per instruction, then 2->6->7.
  - out_value=8, halted=1, invalid_count=0.
- Arithmetic and wrap: r1=200, r2=100.
  - sub r4,r1,r2 -> out_value=100.
  - add r4,r1,r2 -> out_value=44 (wrap).
  - slt r4,r2,r1 with r1=8'hF0 -> out_value=0 (-16 < 100 signed).
- Invalid instruction: opcode 6'h3E targeting r4, then halt.
  - instruction_invalid=1 through WB; r4 stays 0, out_value=0, invalid_count=1.
- rd=0: addiu r0,r0,7; add r4,r0,r0; halt -> out_value=0.
- Program of 32 addiu r4,r4,1 with no halt, PC_W=5:
  - 32nd WB -> OUTPUT, no refetch of address 0, out_value=32.
- Reset and restart:
  - rstn low during EX of instruction 2 -> state=0 immediately; no WB write.
  - Start again -> same result as an uninterrupted run.
  - start held during the run has no effect.
